reg_load_arbiter: RTL and testbench

//  Shares one 8-bit load-enabled register (CLK/RESET/LOAD, D in, Q out) among 4 writers.

---
 rtl/reg_load_arbiter_pkg.sv | 26 ++
 rtl/reg_load_arbiter_if.sv | 44 ++++
 rtl/reg_load_arbiter_rr_pick4.sv | 38 +++
 rtl/reg_load_arbiter.sv | 98 +++++++++
 tb/tb_reg_load_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_load_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_load_arbiter_pkg
// Description : Shared definitions for the register load arbiter: FSM state
//               codes, index width and a one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_load_arbiter_pkg;

    // Width of a requester index (four requesters).
    localparam int c_NREQ_IDX_W = 2;

    // Code 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Converts a requester index to a 4-bit one-hot vector.
    function automatic logic [3:0] f_onehot4(input logic [c_NREQ_IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_load_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_load_arbiter_if
// Description : Bundle between the requesters, the shared load register and
//               the arbiter.
//   REQ/DATA_IN : per-requester request level and data (requester i at
//                 bits [i*WIDTH +: WIDTH])
//   REG_Q       : readback from the shared register
//   LOAD/REG_D  : load enable and data to the shared register
//   GNT/ACK     : one-hot grant (LOAD cycle) and completion strobe
//   ERR/BUSY    : readback mismatch (valid with ACK), arbiter not idle
//   LAST_ID     : index of the requester served most recently
//   Modport master = arbiter side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_load_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) ();
    import reg_load_arbiter_pkg::*;

    logic [NREQ-1:0]        REQ;
    logic [NREQ*WIDTH-1:0]  DATA_IN;
    logic [WIDTH-1:0]       REG_Q;
    logic                   LOAD;
    logic [WIDTH-1:0]       REG_D;
    logic [NREQ-1:0]        GNT;
    logic [NREQ-1:0]        ACK;
    logic                   ERR;
    logic                   BUSY;
    logic [c_NREQ_IDX_W-1:0] LAST_ID;

    modport master (
        input  REQ, DATA_IN, REG_Q,
        output LOAD, REG_D, GNT, ACK, ERR, BUSY, LAST_ID
    );

    modport slave (
        output REQ, DATA_IN, REG_Q,
        input  LOAD, REG_D, GNT, ACK, ERR, BUSY, LAST_ID
    );

endinterface
`default_nettype wire

// File: rtl/reg_load_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin picker. Returns the first set
//               request bit scanning i_ptr, i_ptr+1, ... (mod 4).
//   i_req   : request vector
//   i_ptr   : scan start position
//   o_valid : any request set
//   o_idx   : winning index (equals i_ptr when o_valid is low)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import reg_load_arbiter_pkg::*;
(
    input  wire logic [3:0]              i_req,
    input  wire logic [c_NREQ_IDX_W-1:0] i_ptr,
    output logic                         o_valid,
    output logic [c_NREQ_IDX_W-1:0]      o_idx
);

    logic [c_NREQ_IDX_W-1:0] w_cand;

    // Scan from the farthest offset down to the pointer so the closest
    // set bit (in rotation order) is written last and wins.
    always_comb begin
        o_valid = |i_req;
        o_idx   = i_ptr;
        w_cand  = '0;
        for (int k = 3; k >= 0; k--) begin
            w_cand = i_ptr + c_NREQ_IDX_W'(k);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_load_arbiter
// Description : Shares one load-enabled register among four writers. Round
//               robin grant, a single LOAD pulse per write, then a readback
//               comparison of the register output.
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : reg_load_arbiter_if master modport (requests, data,
//                register readback in; LOAD/REG_D/GNT/ACK/ERR/BUSY/LAST_ID out)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_load_arbiter
    import reg_load_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  wire logic            CLK,
    input  wire logic            RESET,
    reg_load_arbiter_if.master   bus
);

    state_t                  state_q,   state_d;
    logic [c_NREQ_IDX_W-1:0] idx_q,     idx_d;
    logic [c_NREQ_IDX_W-1:0] ptr_q,     ptr_d;
    logic [c_NREQ_IDX_W-1:0] last_id_q, last_id_d;
    logic [WIDTH-1:0]        reg_d_q,   reg_d_d;

    logic                    w_pick_valid;
    logic [c_NREQ_IDX_W-1:0] w_pick_idx;

    rr_pick4 u_pick (
        .i_req   (bus.REQ),
        .i_ptr   (ptr_q),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        last_id_d = last_id_q;
        reg_d_d   = reg_d_q;
        case (state_q)
            ST_IDLE: begin
                // Data is captured only here, so requesters may change
                // DATA_IN once granted.
                if (w_pick_valid) begin
                    idx_d   = w_pick_idx;
                    reg_d_d = bus.DATA_IN[32'(w_pick_idx)*WIDTH +: WIDTH];
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                ptr_d     = idx_q + 1'b1;
                last_id_d = idx_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            last_id_q <= '0;
            reg_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            last_id_q <= last_id_d;
            reg_d_q   <= reg_d_d;
        end
    end

    // Outputs decode registered state only; no path from REQ.
    // ERR compares the register's own output, which has settled by CHECK.
    always_comb begin
        bus.LOAD    = (state_q == ST_WRITE);
        bus.REG_D   = reg_d_q;
        bus.GNT     = (state_q == ST_WRITE) ? f_onehot4(idx_q) : '0;
        bus.ACK     = (state_q == ST_CHECK) ? f_onehot4(idx_q) : '0;
        bus.ERR     = (state_q == ST_CHECK) && (bus.REG_Q != reg_d_q);
        bus.BUSY    = (state_q != ST_IDLE);
        bus.LAST_ID = last_id_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_load_arbiter
// Description : Self-checking bench for reg_load_arbiter with a behavioural
//               load register (optional stuck-at-0 bits on its output).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_load_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] reg_q;
    logic [7:0] stuck = 8'h00;

    reg_load_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

    reg_load_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared register, reset by the same RESET.
    always @(posedge clk) begin
        if (rst)           reg_q <= 8'h00;
        else if (bus.LOAD) reg_q <= bus.REG_D;
    end
    assign bus.REG_Q = reg_q & ~stuck;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic [7:0]  stk;
        logic [1:0]  exp_idx;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requests must already be applied; expects LOAD in the next cycle.
    task automatic write_check(input logic [1:0] eidx, input logic [7:0] edata, input logic eerr);
        int waited;
        waited = 0;
        @(posedge clk); #1;
        while (!bus.LOAD && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.LOAD) begin
            n_cmp++;
            n_err++;
            $display("FAIL load_timeout: no LOAD within 8 cycles, expected idx %0d", eidx);
            bus.REQ = 4'b0000;
            return;
        end
        chk("latency",  32'(waited), 32'd0);
        chk("gnt",      bus.GNT, 4'b0001 << eidx);
        chk("reg_d",    bus.REG_D, edata);
        chk("ack_in_w", bus.ACK, 4'b0000);
        @(posedge clk); #1;
        chk("load_off", bus.LOAD, 1'b0);
        chk("ack",      bus.ACK, 4'b0001 << eidx);
        chk("err",      bus.ERR, eerr);
        chk("reg_q",    bus.REG_Q, edata & ~stuck);
        @(posedge clk); #1;
        bus.REQ = 4'b0000;
        chk("last_id",  bus.LAST_ID, eidx);
        chk("busy_off", bus.BUSY, 1'b0);
        chk("ack_off",  bus.ACK, 4'b0000);
    endtask

    initial begin : main
        int prev_load;
        int nload;
        logic [31:0] rr_data;
        logic [1:0]  eidx;

        //            req      din            stuck  idx    data   err
        vecs[0] = '{4'b0010, 32'h0000_A500, 8'h00, 2'd1, 8'hA5, 1'b0};
        vecs[1] = '{4'b0100, 32'h003C_0000, 8'h00, 2'd2, 8'h3C, 1'b0};
        vecs[2] = '{4'b0101, 32'h0022_0011, 8'h00, 2'd0, 8'h11, 1'b0};
        vecs[3] = '{4'b0100, 32'h0022_0011, 8'h00, 2'd2, 8'h22, 1'b0};
        vecs[4] = '{4'b0001, 32'h0000_005A, 8'h00, 2'd0, 8'h5A, 1'b0};
        vecs[5] = '{4'b1000, 32'hC300_0000, 8'h00, 2'd3, 8'hC3, 1'b0};
        vecs[6] = '{4'b1010, 32'h8800_7700, 8'h00, 2'd1, 8'h77, 1'b0};
        vecs[7] = '{4'b1001, 32'hAA00_0099, 8'h00, 2'd3, 8'hAA, 1'b0};
        vecs[8] = '{4'b0001, 32'h0000_0001, 8'h01, 2'd0, 8'h01, 1'b1};
        vecs[9] = '{4'b0001, 32'h0000_0002, 8'h01, 2'd0, 8'h02, 1'b0};

        bus.REQ     = 4'b0000;
        bus.DATA_IN = 32'h0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load", bus.LOAD, 1'b0);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_regd", bus.REG_D, 8'h00);
        rst = 1'b0;

        // Reset held two cycles while in WRITE.
        bus.REQ     = 4'b0001;
        bus.DATA_IN = 32'h0000_00EE;
        @(posedge clk); #1;
        chk("pre_rst_load", bus.LOAD, 1'b1);
        rst     = 1'b1;
        bus.REQ = 4'b0000;
        @(posedge clk); #1;
        chk("rst_no_ack", bus.ACK, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_load",   bus.LOAD, 1'b0);
        chk("mid_gnt",    bus.GNT, 4'b0000);
        chk("mid_ack",    bus.ACK, 4'b0000);
        chk("mid_err",    bus.ERR, 1'b0);
        chk("mid_busy",   bus.BUSY, 1'b0);
        chk("mid_lastid", bus.LAST_ID, 2'd0);
        chk("mid_regd",   bus.REG_D, 8'h00);
        chk("mid_regq",   bus.REG_Q, 8'h00);
        @(posedge clk); #1;
        chk("post_rst_ack",  bus.ACK, 4'b0000);
        chk("post_rst_busy", bus.BUSY, 1'b0);

        // Round robin with all four requests held.
        rr_data     = 32'h4433_2211;
        bus.DATA_IN = rr_data;
        bus.REQ     = 4'b1111;
        prev_load   = 0;
        for (int k = 0; k < 5; k++) begin
            int waited;
            eidx   = 2'(k % 4);
            waited = 0;
            @(posedge clk); #1;
            while (!bus.LOAD && waited < 8) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!bus.LOAD) begin
                n_cmp++;
                n_err++;
                $display("FAIL rr_timeout: no LOAD for round-robin grant %0d", k);
                break;
            end
            chk("rr_gnt",  bus.GNT, 4'b0001 << eidx);
            chk("rr_regd", bus.REG_D, (rr_data >> (8 * eidx)) & 32'hFF);
            if (k > 0) chk("rr_spacing", 32'(cyc - prev_load), 32'd3);
            prev_load = cyc;
            @(posedge clk); #1;
            chk("rr_ack", bus.ACK, 4'b0001 << eidx);
            chk("rr_err", bus.ERR, 1'b0);
            @(posedge clk); #1;
            chk("rr_lastid", bus.LAST_ID, eidx);
            if (k == 4) bus.REQ = 4'b0000;
        end
        @(posedge clk); #1;

        // Table of single writes (wrap, skip, readback fault).
        for (int i = 0; i < 10; i++) begin
            stuck       = vecs[i].stk;
            bus.DATA_IN = vecs[i].din;
            bus.REQ     = vecs[i].req;
            write_check(vecs[i].exp_idx, vecs[i].exp_data, vecs[i].exp_err);
        end
        stuck = 8'h00;

        // Request drop during WRITE; data changes after the grant edge.
        bus.DATA_IN = 32'h006E_0000;
        bus.REQ     = 4'b0100;
        @(posedge clk); #1;
        chk("drop_load", bus.LOAD, 1'b1);
        chk("drop_gnt",  bus.GNT, 4'b0100);
        bus.REQ     = 4'b0000;
        bus.DATA_IN = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("drop_ack",  bus.ACK, 4'b0100);
        chk("drop_err",  bus.ERR, 1'b0);
        chk("drop_regq", bus.REG_Q, 8'h6E);
        nload = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.LOAD) nload++;
        end
        chk("drop_no_regrant", 32'(nload), 32'd0);
        chk("drop_lastid", bus.LAST_ID, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
